// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo: store-and-forward frame buffer from the rx stream (rxd/rx_dv)
// to the tx stream (txd/tx_en). A frame is only forwarded once it has been
// received completely. A frame that does not fit is discarded as a whole.
// Frames leave back to back, separated by a guaranteed idle gap of IFG cycles.
//
// Optional feature: define STREAM_PKT_FIFO_STATS_EN to add the saturating
// rx_frame_cnt / drop_frame_cnt statistics outputs.
//
// TX FSM states
//   state   | meaning
//   TX_IDLE | no frame in progress; leave when a complete frame is buffered
//   TX_SEND | one buffered word per cycle on txd with tx_en=1, until last flag
//   TX_GAP  | inter-frame gap, tx_en=0 and txd=0 (IDLE supplies the final gap cycle)

module stream_pkt_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 64,
   parameter int IFG   = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            rxd,
   input  logic                     rx_dv,
   output logic [DW-1:0]            txd,
   output logic                     tx_en,
   output logic                     drop_pulse,
   output logic [$clog2(DEPTH):0]   level
`ifdef STREAM_PKT_FIFO_STATS_EN
   ,
   output logic [15:0]              rx_frame_cnt,
   output logic [15:0]              drop_frame_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = $clog2(IFG) + 1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_GAP
   } tx_state_t;

   tx_state_t       tx_state;
   logic [DW-1:0]   mem_data [DEPTH];
   logic            mem_last [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   commit_ptr;
   logic [PW-1:0]   last_ptr;
   logic [PW-1:0]   frame_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            rx_in_frame;
   logic            rx_bad;

   logic            full;
   logic            rd_en;
   logic            rd_last;
   logic            wr_en;
   logic            overflow;
   logic            commit;
   logic            drop;
   logic            tx_done;

   // A read in the same cycle frees a slot, so a write at full is only an
   // overflow when the tx side is not reading.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en    = (tx_state == TX_SEND);
   assign rd_last  = mem_last[rd_ptr[AW-1:0]];
   assign overflow = rx_dv && !rx_bad && full && !rd_en;
   assign wr_en    = rx_dv && !rx_bad && !overflow;
   assign commit   = !rx_dv && rx_in_frame && !rx_bad;
   assign drop     = !rx_dv && rx_bad;
   assign tx_done  = rd_en && rd_last;
   assign last_ptr = wr_ptr - PW'(1);

   // Only committed words count; the frame being received is invisible here.
   assign level    = commit_ptr - rd_ptr;

   // Storage array: data written as it arrives, last flag patched on commit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr[AW-1:0]] <= rxd;
         mem_last[wr_ptr[AW-1:0]] <= 1'b0;
      end
      if (commit) begin
         mem_last[last_ptr[AW-1:0]] <= 1'b1;
      end
   end

   // RX framing: write pointer, commit point and drop handling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         commit_ptr  <= '0;
         rx_in_frame <= 1'b0;
         rx_bad      <= 1'b0;
         drop_pulse  <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         if (rx_dv) begin
            rx_in_frame <= 1'b1;
            if (overflow) begin
               // Rewind so the partial frame vanishes; the rest is ignored.
               rx_bad <= 1'b1;
               wr_ptr <= commit_ptr;
            end else if (wr_en) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
         end else begin
            rx_in_frame <= 1'b0;
            rx_bad      <= 1'b0;
            if (drop) begin
               drop_pulse <= 1'b1;
            end
            if (commit) begin
               commit_ptr <= wr_ptr;
            end
         end
      end
   end

   // Count of complete frames waiting; commit and tx completion may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else begin
         case ({commit, tx_done})
            2'b10:   frame_cnt <= frame_cnt + PW'(1);
            2'b01:   frame_cnt <= frame_cnt - PW'(1);
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

   // TX FSM with registered txd/tx_en and the inter-frame gap timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         txd      <= '0;
         tx_en    <= 1'b0;
         rd_ptr   <= '0;
         gap_cnt  <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               txd   <= '0;
               tx_en <= 1'b0;
               if (frame_cnt != '0) begin
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               txd    <= mem_data[rd_ptr[AW-1:0]];
               tx_en  <= 1'b1;
               rd_ptr <= rd_ptr + PW'(1);
               if (rd_last) begin
                  // The IDLE cycle contributes one gap cycle of its own.
                  if (IFG > 1) begin
                     tx_state <= TX_GAP;
                     gap_cnt  <= GW'(IFG - 1);
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end
            end
            TX_GAP: begin
               txd   <= '0;
               tx_en <= 1'b0;
               if (gap_cnt <= GW'(1)) begin
                  tx_state <= TX_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: begin
               tx_state <= TX_IDLE;
               txd      <= '0;
               tx_en    <= 1'b0;
            end
         endcase
      end
   end

`ifdef STREAM_PKT_FIFO_STATS_EN
   // Saturating frame statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_frame_cnt   <= '0;
         drop_frame_cnt <= '0;
      end else begin
         if (commit && (rx_frame_cnt != 16'hFFFF)) begin
            rx_frame_cnt <= rx_frame_cnt + 16'd1;
         end
         if (drop && (drop_frame_cnt != 16'hFFFF)) begin
            drop_frame_cnt <= drop_frame_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
